uart_fifo_core: RTL
===================

// Module: uart_fifo_core
// PURPOSE
//  Parametrised UART: 16x-oversampled receiver and transmitter, an internal baud-tick divider,
//  and an RX FIFO and a TX FIFO between the serial line and the host.
//  Adds optional parity, 1/1.5/2 stop bits, and sticky framing/parity/overrun flags.
//  Sits between the board rx/tx pins and the debug unit or the MIPS I/O bus.
// PARAMETERS
//  DBIT       8    data bits per frame, 5..9, sent and received LSB first
//  SB_TICK    16   stop-bit length in oversample ticks: 16 = 1, 24 = 1.5, 32 = 2 stop bits
//  CLK_DIV    163  sys clocks per oversample tick (50 MHz / (19200*16)); must be >= 2
//  FIFO_AW    4    FIFO address width; each FIFO holds 2**FIFO_AW entries
//  PARITY_EN  0    1 = a parity bit follows the data bits
//  PARITY_ODD 0    1 = odd parity, 0 = even (ignored when PARITY_EN = 0)
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  rx         in   1        serial input (asynchronous to clk)
//  tx         out  1        serial output, idle high
//  rd         in   1        pop the RX FIFO head (1-cycle strobe)
//  r_data     out  DBIT     RX FIFO head (show-ahead)
//  rx_empty   out  1        RX FIFO empty
//  wr         in   1        push w_data into the TX FIFO (1-cycle strobe)
//  w_data     in   DBIT     byte to transmit
//  tx_full    out  1        TX FIFO full
//  tx_busy    out  1        TX FSM not in IDLE, or TX FIFO not empty
//  frame_err  out  1        sticky: stop bit sampled low
//  par_err    out  1        sticky: parity mismatch
//  overrun    out  1        sticky: byte completed while the RX FIFO was full
//  err_clr    in   1        clears all three sticky flags
// BEHAVIOUR
//  Reset: tx=1, rx_empty=1, tx_full=0, tx_busy=0, all flags=0, r_data=0, both FIFOs emptied,
//   FSMs to IDLE, divider=0. Reset mid-frame aborts the frame; tx goes high immediately.
//  Divider: counts 0..CLK_DIV-1 and pulses tick for 1 clk when count=CLK_DIV-1. Free-running.
//  rx passes through a 2-flop synchroniser before use; tx is driven from a register.
//  RX FSM IDLE/START/DATA/PAR/STOP:
//   IDLE -> START on synchronised rx=0.
//   START: at tick 7, rx=1 means a glitch -> IDLE; otherwise -> DATA with the tick count cleared.
//   Each later bit is sampled at its 16th tick (mid-bit).
//   DATA shifts DBIT bits in LSB first, then goes to PAR if PARITY_EN, else to STOP.
//   STOP samples at tick SB_TICK, then the byte is pushed and the FSM returns to IDLE.
//   Stop=0: frame_err=1, byte discarded. Parity mismatch: par_err=1, byte discarded.
//   FIFO full at push: overrun=1, new byte dropped, FIFO contents kept.
//  TX FSM IDLE/START/DATA/PAR/STOP:
//   IDLE with TX FIFO non-empty: pop the head, then tx=0 on the next clk.
//   Start and each data/parity bit last 16 ticks. Stop (tx=1) lasts SB_TICK ticks.
//   Back-to-back frames have no idle gap.
//  FIFOs: circular buffers with binary pointers and a count of FIFO_AW+1 bits.
//   wr while full and rd while empty are ignored, with no pointer movement.
//   Push and pop in the same cycle are both honoured, count unchanged, including on a full FIFO.
//   r_data shows the head combinationally from storage, masked to 0 while rx_empty=1.
//   A pop takes effect at the clock edge; the new head is visible the following cycle.
//  Flags: set has priority over err_clr in the same cycle.
//  Latency: wr into an empty idle TX path gives tx=0 at wr+2 clks. The last RX stop sample
//   gives rx_empty=0 at +1 clk, plus 2 clks of synchroniser delay from the pin.
// TESTING
//  CLK_DIV=4, DBIT=8, no parity: wr 0xA5 -> tx frame 0,1,0,1,0,0,1,0,1,1, each bit 64 clks;
//   tx_busy falls after the stop bit.
//  Loop tx to rx, wr 0x00,0xFF,0x3C -> r_data 0x00,0xFF,0x3C in order via rd; no flags set.
//  FIFO_AW=2: wr 6 bytes while the first is sending -> tx_full after 5 (4 queued + 1 popped);
//   6th wr ignored; 5 bytes sent.
//  Send 5 frames with no rd, FIFO_AW=2 -> 4 bytes kept, overrun=1; err_clr -> 0.
//  Drive stop bit 0 -> frame_err=1, rx_empty stays 1.
//   PARITY_EN=1, even, send 0x07 with parity 0 -> par_err=1.
//  rx low pulse of 5 ticks -> no byte, FSM back to IDLE.
//   rst_n low mid-TX frame -> tx=1 at once; the FIFO is empty after release.

Source files
------------

// File: rtl/uart_fifo_core.sv
// UART core: 16x-oversampled receiver and transmitter, free-running baud-tick divider,
// RX/TX FIFOs towards the host, optional parity and sticky framing/parity/overrun flags.
module uart_fifo_core #(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned CLK_DIV    = 163,
    parameter int unsigned FIFO_AW    = 4,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_rx,
    output logic            o_tx,
    input  logic            i_rd,
    output logic [DBIT-1:0] o_r_data,
    output logic            o_rx_empty,
    input  logic            i_wr,
    input  logic [DBIT-1:0] i_w_data,
    output logic            o_tx_full,
    output logic            o_tx_busy,
    output logic            o_frame_err,
    output logic            o_par_err,
    output logic            o_overrun,
    input  logic            i_err_clr
);

    localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DEPTH    = 1 << FIFO_AW;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [5:0]  SB_LAST  = 6'(SB_TICK - 1);
    localparam logic [3:0]  N_LAST   = 4'(DBIT - 1);
    localparam logic        PAR_EN   = (PARITY_EN != 0);
    localparam logic        PAR_ODD  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

    // ---------------- baud tick divider ----------------
    logic [DW-1:0] r_div_cnt;
    logic          w_tick;

    assign w_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

    // ---------------- rx synchroniser ----------------
    logic r_rx_meta, r_rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ---------------- receiver FSM ----------------
    state_e          r_rx_state, w_rx_state_nxt;
    logic [5:0]      r_rx_s, w_rx_s_nxt;
    logic [3:0]      r_rx_n, w_rx_n_nxt;
    logic [DBIT-1:0] r_rx_b, w_rx_b_nxt;
    logic            r_rx_p, w_rx_p_nxt;
    logic            w_rx_done;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_s_nxt     = r_rx_s;
        w_rx_n_nxt     = r_rx_n;
        w_rx_b_nxt     = r_rx_b;
        w_rx_p_nxt     = r_rx_p;
        w_rx_done      = 1'b0;
        unique case (r_rx_state)
            StIdle: begin
                if (!r_rx_sync) begin
                    w_rx_state_nxt = StStart;
                    w_rx_s_nxt     = '0;
                end
            end
            StStart: begin
                if (w_tick) begin
                    if (r_rx_s == 6'd7) begin
                        // line back high by mid start bit: treat as a glitch
                        if (r_rx_sync) begin
                            w_rx_state_nxt = StIdle;
                        end else begin
                            w_rx_state_nxt = StData;
                            w_rx_s_nxt     = '0;
                            w_rx_n_nxt     = '0;
                        end
                    end else begin
                        w_rx_s_nxt = r_rx_s + 6'd1;
                    end
                end
            end
            StData: begin
                if (w_tick) begin
                    if (r_rx_s == 6'd15) begin
                        w_rx_s_nxt = '0;
                        w_rx_b_nxt = {r_rx_sync, r_rx_b[DBIT-1:1]};
                        if (r_rx_n == N_LAST) w_rx_state_nxt = PAR_EN ? StPar : StStop;
                        else                  w_rx_n_nxt     = r_rx_n + 4'd1;
                    end else begin
                        w_rx_s_nxt = r_rx_s + 6'd1;
                    end
                end
            end
            StPar: begin
                if (w_tick) begin
                    if (r_rx_s == 6'd15) begin
                        w_rx_s_nxt     = '0;
                        w_rx_p_nxt     = r_rx_sync;
                        w_rx_state_nxt = StStop;
                    end else begin
                        w_rx_s_nxt = r_rx_s + 6'd1;
                    end
                end
            end
            StStop: begin
                if (w_tick) begin
                    if (r_rx_s == SB_LAST) begin
                        w_rx_done      = 1'b1;
                        w_rx_state_nxt = StIdle;
                    end else begin
                        w_rx_s_nxt = r_rx_s + 6'd1;
                    end
                end
            end
            default: w_rx_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= StIdle;
            r_rx_s     <= '0;
            r_rx_n     <= '0;
            r_rx_b     <= '0;
            r_rx_p     <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_s     <= w_rx_s_nxt;
            r_rx_n     <= w_rx_n_nxt;
            r_rx_b     <= w_rx_b_nxt;
            r_rx_p     <= w_rx_p_nxt;
        end
    end

    // ---------------- RX FIFO and error flags ----------------
    logic [DBIT-1:0]    r_rxf_mem [DEPTH];
    logic [FIFO_AW-1:0] r_rxf_wptr, r_rxf_rptr;
    logic [FIFO_AW:0]   r_rxf_cnt;
    logic w_rxf_empty, w_rxf_full, w_rxf_push, w_rxf_pop;
    logic w_stop_bad, w_par_bad, w_rx_ok, w_rx_overrun;
    logic r_frame_err, r_par_err, r_overrun;

    assign w_rxf_empty  = (r_rxf_cnt == '0);
    assign w_rxf_full   = r_rxf_cnt[FIFO_AW];
    assign w_rxf_pop    = i_rd && !w_rxf_empty;
    assign w_stop_bad   = !r_rx_sync;
    assign w_par_bad    = PAR_EN && ((^r_rx_b ^ r_rx_p) != PAR_ODD);
    assign w_rx_ok      = w_rx_done && !w_stop_bad && !w_par_bad;
    assign w_rxf_push   = w_rx_ok && (!w_rxf_full || w_rxf_pop);
    assign w_rx_overrun = w_rx_ok && w_rxf_full && !w_rxf_pop;

    always_ff @(posedge clk) begin
        if (w_rxf_push) r_rxf_mem[r_rxf_wptr] <= r_rx_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxf_wptr <= '0;
            r_rxf_rptr <= '0;
            r_rxf_cnt  <= '0;
        end else begin
            if (w_rxf_push) r_rxf_wptr <= r_rxf_wptr + 1'b1;
            if (w_rxf_pop)  r_rxf_rptr <= r_rxf_rptr + 1'b1;
            case ({w_rxf_push, w_rxf_pop})
                2'b10:   r_rxf_cnt <= r_rxf_cnt + 1'b1;
                2'b01:   r_rxf_cnt <= r_rxf_cnt - 1'b1;
                default: r_rxf_cnt <= r_rxf_cnt;
            endcase
        end
    end

    // a new error event wins over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_par_err   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_rx_done && w_stop_bad) r_frame_err <= 1'b1;
            else if (i_err_clr)          r_frame_err <= 1'b0;
            if (w_rx_done && w_par_bad)  r_par_err <= 1'b1;
            else if (i_err_clr)          r_par_err <= 1'b0;
            if (w_rx_overrun)            r_overrun <= 1'b1;
            else if (i_err_clr)          r_overrun <= 1'b0;
        end
    end

    assign o_r_data    = w_rxf_empty ? '0 : r_rxf_mem[r_rxf_rptr];
    assign o_rx_empty  = w_rxf_empty;
    assign o_frame_err = r_frame_err;
    assign o_par_err   = r_par_err;
    assign o_overrun   = r_overrun;

    // ---------------- TX FIFO ----------------
    logic [DBIT-1:0]    r_txf_mem [DEPTH];
    logic [FIFO_AW-1:0] r_txf_wptr, r_txf_rptr;
    logic [FIFO_AW:0]   r_txf_cnt;
    logic [DBIT-1:0]    w_txf_head;
    logic w_txf_empty, w_txf_full, w_txf_push, w_txf_pop;

    assign w_txf_empty = (r_txf_cnt == '0);
    assign w_txf_full  = r_txf_cnt[FIFO_AW];
    assign w_txf_head  = r_txf_mem[r_txf_rptr];
    assign w_txf_push  = i_wr && (!w_txf_full || w_txf_pop);

    always_ff @(posedge clk) begin
        if (w_txf_push) r_txf_mem[r_txf_wptr] <= i_w_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txf_wptr <= '0;
            r_txf_rptr <= '0;
            r_txf_cnt  <= '0;
        end else begin
            if (w_txf_push) r_txf_wptr <= r_txf_wptr + 1'b1;
            if (w_txf_pop)  r_txf_rptr <= r_txf_rptr + 1'b1;
            case ({w_txf_push, w_txf_pop})
                2'b10:   r_txf_cnt <= r_txf_cnt + 1'b1;
                2'b01:   r_txf_cnt <= r_txf_cnt - 1'b1;
                default: r_txf_cnt <= r_txf_cnt;
            endcase
        end
    end

    // ---------------- transmitter FSM ----------------
    state_e          r_tx_state, w_tx_state_nxt;
    logic [5:0]      r_tx_s, w_tx_s_nxt;
    logic [3:0]      r_tx_n, w_tx_n_nxt;
    logic [DBIT-1:0] r_tx_b, w_tx_b_nxt;
    logic            r_tx_p, w_tx_p_nxt;
    logic            r_tx, w_tx_nxt;

    // r_tx is loaded with the level of the bit being entered, so tx changes on that edge
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_s_nxt     = r_tx_s;
        w_tx_n_nxt     = r_tx_n;
        w_tx_b_nxt     = r_tx_b;
        w_tx_p_nxt     = r_tx_p;
        w_tx_nxt       = r_tx;
        w_txf_pop      = 1'b0;
        unique case (r_tx_state)
            StIdle: begin
                w_tx_nxt = 1'b1;
                if (!w_txf_empty) begin
                    w_txf_pop      = 1'b1;
                    w_tx_b_nxt     = w_txf_head;
                    w_tx_p_nxt     = ^w_txf_head ^ PAR_ODD;
                    w_tx_s_nxt     = '0;
                    w_tx_state_nxt = StStart;
                    w_tx_nxt       = 1'b0;
                end
            end
            StStart: begin
                if (w_tick) begin
                    if (r_tx_s == 6'd15) begin
                        w_tx_s_nxt     = '0;
                        w_tx_n_nxt     = '0;
                        w_tx_state_nxt = StData;
                        w_tx_nxt       = r_tx_b[0];
                    end else begin
                        w_tx_s_nxt = r_tx_s + 6'd1;
                    end
                end
            end
            StData: begin
                if (w_tick) begin
                    if (r_tx_s == 6'd15) begin
                        w_tx_s_nxt = '0;
                        w_tx_b_nxt = r_tx_b >> 1;
                        if (r_tx_n == N_LAST) begin
                            w_tx_state_nxt = PAR_EN ? StPar : StStop;
                            w_tx_nxt       = PAR_EN ? r_tx_p : 1'b1;
                        end else begin
                            w_tx_n_nxt = r_tx_n + 4'd1;
                            w_tx_nxt   = r_tx_b[1];
                        end
                    end else begin
                        w_tx_s_nxt = r_tx_s + 6'd1;
                    end
                end
            end
            StPar: begin
                if (w_tick) begin
                    if (r_tx_s == 6'd15) begin
                        w_tx_s_nxt     = '0;
                        w_tx_state_nxt = StStop;
                        w_tx_nxt       = 1'b1;
                    end else begin
                        w_tx_s_nxt = r_tx_s + 6'd1;
                    end
                end
            end
            StStop: begin
                if (w_tick) begin
                    if (r_tx_s == SB_LAST) begin
                        w_tx_s_nxt = '0;
                        if (!w_txf_empty) begin
                            w_txf_pop      = 1'b1;
                            w_tx_b_nxt     = w_txf_head;
                            w_tx_p_nxt     = ^w_txf_head ^ PAR_ODD;
                            w_tx_state_nxt = StStart;
                            w_tx_nxt       = 1'b0;
                        end else begin
                            w_tx_state_nxt = StIdle;
                            w_tx_nxt       = 1'b1;
                        end
                    end else begin
                        w_tx_s_nxt = r_tx_s + 6'd1;
                    end
                end
            end
            default: begin
                w_tx_state_nxt = StIdle;
                w_tx_nxt       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= StIdle;
            r_tx_s     <= '0;
            r_tx_n     <= '0;
            r_tx_b     <= '0;
            r_tx_p     <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_s     <= w_tx_s_nxt;
            r_tx_n     <= w_tx_n_nxt;
            r_tx_b     <= w_tx_b_nxt;
            r_tx_p     <= w_tx_p_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    assign o_tx      = r_tx;
    assign o_tx_full = w_txf_full;
    assign o_tx_busy = (r_tx_state != StIdle) || !w_txf_empty;

endmodule
